// File: rtl/spi_txn_arbiter_sp3a.sv
// spi_txn_arbiter_sp3a: round-robin transaction scheduler in front of the single
// spi_controller_SP3A. Accepts one descriptor at a time, drives the controller
// descriptor from registers until done, then parks it with spi_data_len = 0.
// Optional watchdog abort is built when SPI_ARB_WATCHDOG_EN is defined.
module spi_txn_arbiter_sp3a #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned IDLE_GAP       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                                            axi_clk,
    input  logic                                            reset,
    input  logic [NUM_REQ-1:0]                              req_valid,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic [NUM_REQ-1:0]                              req_wnr,
    input  logic [NUM_REQ*10-1:0]                           req_addr,
    input  logic [NUM_REQ*8-1:0]                            req_len,
    input  logic [NUM_REQ*2-1:0]                            req_opgrp,
    output logic [NUM_REQ-1:0]                              resp_done,
    output logic                                            resp_timeout,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
    output logic                                            busy,
    output logic                                            WnR,
    output logic [9:0]                                      spi_address,
    output logic [7:0]                                      spi_data_len,
    output logic [1:0]                                      spi_opcode_group,
    input  logic                                            done
);

    localparam int unsigned OwnerW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so pointer + offset never wraps before the explicit modulo.
    localparam int unsigned CandW  = OwnerW + 1;
    localparam int unsigned GapW   = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    // Elaboration-time guard on parameter ranges.
    if (NUM_REQ < 2 || NUM_REQ > 8 || IDLE_GAP < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("spi_txn_arbiter_sp3a: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e state_q, state_d;

    logic [OwnerW-1:0]  ptr_q, ptr_d;
    logic [OwnerW-1:0]  owner_q, owner_d;
    logic [OwnerW-1:0]  grant_idx;
    logic               grant_found;
    logic [CandW-1:0]   cand;
    logic [NUM_REQ-1:0] grant_oh;

    logic [9:0] addr_arr  [NUM_REQ];
    logic [7:0] len_arr   [NUM_REQ];
    logic [1:0] opgrp_arr [NUM_REQ];

    logic       wnr_q, wnr_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [1:0] opgrp_q, opgrp_d;
    logic       busy_q, busy_d;
    logic [NUM_REQ-1:0] resp_done_q, resp_done_d;
    logic       resp_timeout_q, resp_timeout_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

    logic accept;
    logic issue_end;
    logic issue_timeout;
    logic gap_end;

    // Unpack the flat per-requester descriptor buses.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*10 +: 10];
        assign len_arr[i]   = req_len[i*8 +: 8];
        assign opgrp_arr[i] = req_opgrp[i*2 +: 2];
    end

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = CandW'(ptr_q) + CandW'(k);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[OwnerW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[OwnerW-1:0];
            end
        end
    end

    assign accept    = (state_q == StIdle) && grant_found;
    assign grant_oh  = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign req_ready = grant_oh;

    assign issue_end = (state_q == StIssue) && done;
    assign gap_end   = (state_q == StGap) && (gap_cnt_q == GapW'(IDLE_GAP - 1));

`ifdef SPI_ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);

    logic [WdW-1:0] wd_cnt_q;

    // Watchdog counts ISSUE cycles; it sits at 0 everywhere else so entry starts clean.
    always_ff @(posedge axi_clk) begin
        if (reset || state_q != StIssue) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + WdW'(1);
        end
    end

    // done on the expiry cycle takes priority over the abort.
    assign issue_timeout = (state_q == StIssue) && !done &&
                           (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));
`else
    assign issue_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (len_arr[grant_idx] != 8'd0) ? StIssue : StGap;
                end
            end
            StIssue: begin
                if (issue_end || issue_timeout) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values; WnR, address and opgroup persist after done.
    always_comb begin
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        wnr_d          = wnr_q;
        addr_d         = addr_q;
        len_d          = len_q;
        opgrp_d        = opgrp_q;
        busy_d         = busy_q;
        resp_done_d    = '0;
        resp_timeout_d = 1'b0;
        gap_cnt_d      = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    owner_d   = grant_idx;
                    busy_d    = 1'b1;
                    gap_cnt_d = '0;
                    ptr_d     = (grant_idx == OwnerW'(NUM_REQ - 1)) ? '0
                                                                    : grant_idx + OwnerW'(1);
                    if (len_arr[grant_idx] != 8'd0) begin
                        wnr_d   = req_wnr[grant_idx];
                        addr_d  = addr_arr[grant_idx];
                        len_d   = len_arr[grant_idx];
                        opgrp_d = opgrp_arr[grant_idx];
                    end else begin
                        // Zero-length: complete immediately, controller never sees it.
                        resp_done_d = NUM_REQ'(1) << grant_idx;
                    end
                end
            end
            StIssue: begin
                if (issue_end || issue_timeout) begin
                    len_d          = 8'd0;
                    gap_cnt_d      = '0;
                    resp_done_d    = NUM_REQ'(1) << owner_q;
                    resp_timeout_d = issue_timeout;
                end
            end
            StGap: begin
                if (gap_end) begin
                    busy_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset parks the controller by clearing spi_data_len.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            ptr_q          <= '0;
            owner_q        <= '0;
            wnr_q          <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            opgrp_q        <= '0;
            busy_q         <= 1'b0;
            resp_done_q    <= '0;
            resp_timeout_q <= 1'b0;
            gap_cnt_q      <= '0;
        end else begin
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            wnr_q          <= wnr_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            opgrp_q        <= opgrp_d;
            busy_q         <= busy_d;
            resp_done_q    <= resp_done_d;
            resp_timeout_q <= resp_timeout_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign owner            = owner_q;
    assign busy             = busy_q;
    assign WnR              = wnr_q;
    assign spi_address      = addr_q;
    assign spi_data_len     = len_q;
    assign spi_opcode_group = opgrp_q;
    assign resp_done        = resp_done_q;
    assign resp_timeout     = resp_timeout_q;

endmodule

// File: tb/tb_spi_txn_arbiter_sp3a.sv
// Directed bench for spi_txn_arbiter_sp3a (NUM_REQ=2, IDLE_GAP=2).
// Watchdog steps compile in when SPI_ARB_WATCHDOG_EN is defined.
module tb_spi_txn_arbiter_sp3a;

    localparam int unsigned NReq = 2;
    localparam int unsigned Gap  = 2;
`ifdef SPI_ARB_WATCHDOG_EN
    localparam int unsigned Tmo  = 8;
`else
    localparam int unsigned Tmo  = 4096;
`endif

    logic            axi_clk = 1'b0;
    logic            reset   = 1'b1;
    logic [NReq-1:0] req_valid = '0;
    logic [NReq-1:0] req_ready;
    logic [NReq-1:0] req_wnr = '0;
    logic [NReq*10-1:0] req_addr = '0;
    logic [NReq*8-1:0]  req_len = '0;
    logic [NReq*2-1:0]  req_opgrp = '0;
    logic [NReq-1:0] resp_done;
    logic            resp_timeout;
    logic [0:0]      owner;
    logic            busy;
    logic            WnR;
    logic [9:0]      spi_address;
    logic [7:0]      spi_data_len;
    logic [1:0]      spi_opcode_group;
    logic            done = 1'b0;

    int checks = 0;
    int errors = 0;
    int bad;

    spi_txn_arbiter_sp3a #(
        .NUM_REQ        (NReq),
        .IDLE_GAP       (Gap),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .axi_clk          (axi_clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_wnr          (req_wnr),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .req_opgrp        (req_opgrp),
        .resp_done        (resp_done),
        .resp_timeout     (resp_timeout),
        .owner            (owner),
        .busy             (busy),
        .WnR              (WnR),
        .spi_address      (spi_address),
        .spi_data_len     (spi_data_len),
        .spi_opcode_group (spi_opcode_group),
        .done             (done)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task set_req(input int i, input logic wnr, input logic [9:0] addr, input logic [7:0] len,
                 input logic [1:0] opg);
        req_wnr[i]           = wnr;
        req_addr[i*10 +: 10] = addr;
        req_len[i*8 +: 8]    = len;
        req_opgrp[i*2 +: 2]  = opg;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_wnr", 32'(WnR), 32'h0);
        check("rst_addr", 32'(spi_address), 32'h0);
        check("rst_len", 32'(spi_data_len), 32'h0);
        check("rst_opgrp", 32'(spi_opcode_group), 32'h0);
        check("rst_done", 32'(resp_done), 32'h0);
        check("rst_timeout", 32'(resp_timeout), 32'h0);

        // Single write from requester 0, done 40 cycles after descriptor appears
        set_req(0, 1'b1, 10'h02A, 8'd16, 2'd2);
        req_valid = 2'b01;
        #1;
        check("wr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        check("wr_wnr", 32'(WnR), 32'h1);
        check("wr_addr", 32'(spi_address), 32'h2A);
        check("wr_len", 32'(spi_data_len), 32'd16);
        check("wr_opgrp", 32'(spi_opcode_group), 32'h2);
        check("wr_busy", 32'(busy), 32'h1);
        check("wr_owner", 32'(owner), 32'h0);
        check("wr_ready_issue", 32'(req_ready), 32'h0);
        bad = 0;
        repeat (39) begin
            tick();
            if ({WnR, spi_address, spi_data_len, spi_opcode_group} !== {1'b1, 10'h02A, 8'd16, 2'd2}
                || resp_done !== 2'b00 || req_ready !== 2'b00) bad++;
        end
        check("wr_stable", 32'(bad), 32'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wr_len_park", 32'(spi_data_len), 32'h0);
        check("wr_resp_done", 32'(resp_done), 32'h1);
        check("wr_wnr_keep", 32'(WnR), 32'h1);
        check("wr_addr_keep", 32'(spi_address), 32'h2A);
        check("wr_busy_gap", 32'(busy), 32'h1);
        tick();
        check("wr_done_clr", 32'(resp_done), 32'h0);
        check("wr_busy_gap2", 32'(busy), 32'h1);
        tick();
        check("wr_busy_idle", 32'(busy), 32'h0);

        // Zero-length from requester 1: immediate completion, SPI outputs untouched
        set_req(1, 1'b0, 10'h155, 8'd0, 2'd1);
        req_valid = 2'b10;
        #1;
        check("zl_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        check("zl_resp_done", 32'(resp_done), 32'h2);
        check("zl_len", 32'(spi_data_len), 32'h0);
        check("zl_wnr", 32'(WnR), 32'h1);
        check("zl_addr", 32'(spi_address), 32'h2A);
        check("zl_owner", 32'(owner), 32'h1);
        check("zl_busy", 32'(busy), 32'h1);
        tick();
        check("zl_done_clr", 32'(resp_done), 32'h0);
        tick();
        check("zl_busy_idle", 32'(busy), 32'h0);

        // Spurious done in IDLE and in GAP
        done = 1'b1;
        tick();
        done = 1'b0;
        check("sp_idle_done", 32'(resp_done), 32'h0);
        check("sp_idle_busy", 32'(busy), 32'h0);
        set_req(0, 1'b0, 10'h0F0, 8'd5, 2'd1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("sp_len", 32'(spi_data_len), 32'd5);
        check("sp_wnr", 32'(WnR), 32'h0);
        done = 1'b1;
        tick();
        check("sp_exit_done", 32'(resp_done), 32'h1);
        tick();
        done = 1'b0;
        check("sp_gap_done", 32'(resp_done), 32'h0);
        check("sp_gap_len", 32'(spi_data_len), 32'h0);
        check("sp_gap_busy", 32'(busy), 32'h1);
        tick();
        check("sp_busy_idle", 32'(busy), 32'h0);

        // Contention from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 10'h011, 8'd5, 2'd0);
        set_req(1, 1'b0, 10'h122, 8'd7, 2'd3);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("ct_ready", 32'(req_ready), (g % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check("ct_owner", 32'(owner), 32'(g % 2));
            check("ct_len", 32'(spi_data_len), (g % 2 == 0) ? 32'd5 : 32'd7);
            check("ct_ready_issue", 32'(req_ready), 32'h0);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check("ct_resp_done", 32'(resp_done), (g % 2 == 0) ? 32'h1 : 32'h2);
            check("ct_ready_gap", 32'(req_ready), 32'h0);
            tick();
            check("ct_ready_gap2", 32'(req_ready), 32'h0);
            tick();
        end
        req_valid = 2'b00;

        // Reset five cycles after accept
        set_req(0, 1'b1, 10'h3C3, 8'd9, 2'd1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("mr_len", 32'(spi_data_len), 32'd9);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mr_wnr", 32'(WnR), 32'h0);
        check("mr_addr", 32'(spi_address), 32'h0);
        check("mr_len_clr", 32'(spi_data_len), 32'h0);
        check("mr_opgrp", 32'(spi_opcode_group), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_owner", 32'(owner), 32'h0);
        check("mr_done", 32'(resp_done), 32'h0);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        check("mr_ptr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        check("mr_new_len", 32'(spi_data_len), 32'd9);
        check("mr_new_addr", 32'(spi_address), 32'h3C3);
        check("mr_new_busy", 32'(busy), 32'h1);
        check("mr_new_done", 32'(resp_done), 32'h0);

`ifdef SPI_ARB_WATCHDOG_EN
        // Watchdog abort after 8 ISSUE cycles, then done exactly on expiry
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 10'h044, 8'd5, 2'd2);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (7) tick();
        check("wd_pre_done", 32'(resp_done), 32'h0);
        check("wd_pre_len", 32'(spi_data_len), 32'd5);
        tick();
        check("wd_to_done", 32'(resp_done), 32'h1);
        check("wd_to_flag", 32'(resp_timeout), 32'h1);
        check("wd_to_len", 32'(spi_data_len), 32'h0);
        tick();
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (7) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wd_race_done", 32'(resp_done), 32'h1);
        check("wd_race_flag", 32'(resp_timeout), 32'h0);
`else
        // Without the watchdog ISSUE waits indefinitely
        repeat (20) tick();
        check("nowd_len", 32'(spi_data_len), 32'd9);
        check("nowd_busy", 32'(busy), 32'h1);
        check("nowd_done", 32'(resp_done), 32'h0);
        check("nowd_timeout", 32'(resp_timeout), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
